front_panel_input: RTL and testbench
====================================

Name: front_panel_input

Overview:
Front-panel input front end that feeds cpu_control's user-input side. It scans a 4x4 hex keypad, debounces it, and shifts accepted digits into a 16-bit entry value. That value is presented as userInput/inputValid. It also debounces the 13 panel command buttons and issues one-clock b_* pulses, which clear the entry once consumed.

Parameters:
SCAN_CYCLES, 1000, clocks each keypad column is driven before rows are sampled (must be ≥3)
KEY_STABLE, 3, consecutive identical full scans needed to accept a key press or a release
DEB_CYCLES, 50000, clocks between button debounce sample ticks

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
col_n  out  4  keypad column drive, one-hot active low
row_n  in  4  keypad row sense, active low, asynchronous
btn_n  in  13  raw buttons, active low, asynchronous; bit order 0..12 = step, reset, runhalt, storeinc, irq, dec, load, toA, toSP, toX, toY, toPC, clear
b_step, b_reset, b_runhalt, b_storeinc, b_irq, b_dec, b_load, b_toA, b_toSP, b_toX, b_toY, b_toPC  out  1 each  one-clock command pulses
userInput  out  16  entered hex value, most recent digit in [3:0]
inputValid  out  1  high when at least one digit has been entered since the last consume
digit_count  out  3  digits entered, 0..4, saturating; drives the display
key_strobe  out  1  one-clock pulse on each accepted digit

Behaviour:
- Reset values:
  - col_n=4'b1110; all b_* and key_strobe = 0.
  - userInput=0, digit_count=0, inputValid=0.
  - Scan, debounce and key-FSM counters cleared; all debounced button states = released.
- Synchronisers: row_n and btn_n each pass through a 2-FF synchroniser before any use.
- Keypad scan:
  - A column counter advances every SCAN_CYCLES clocks, 0→1→2→3→0.
  - col_n drives the current column low, the others high.
  - Synchronised rows are sampled on the last cycle of each column dwell.
  - A full scan is 4 dwells. Its result is one of: none; single (exactly one key in the whole scan, code = row*4+col, 4 bits); or multi (≥2 keys).
- Key FSM, evaluated at the end of each full scan:
  - IDLE: a single result with the same code for KEY_STABLE consecutive scans → accept the key and go to HELD. The accept asserts key_strobe for one clock and shifts in the digit. A different code or a multi result restarts the count; none resets it.
  - HELD: none for KEY_STABLE consecutive scans → IDLE. No further accepts while in HELD, so there is no auto-repeat.
- Entry shift on accept:
  - userInput <= {userInput[11:0], code}.
  - digit_count <= min(digit_count+1, 4). After 4 digits, older digits fall off the top.
  - inputValid = (digit_count != 0).
- Buttons:
  - A shared tick fires every DEB_CYCLES clocks.
  - Each button keeps its last 3 tick samples. Debounced state → pressed when all 3 samples are pressed, → released when all 3 are released.
  - The corresponding b_* is high for exactly the one clock after the tick that moves the state released→pressed.
  - Simultaneous presses give simultaneous pulses; no priority is applied here.
- Consume:
  - In a cycle where any b_* is high, userInput/inputValid still show the pre-consume value.
  - On the next clock, userInput<=0 and digit_count<=0.
  - A clear press clears userInput and digit_count on its debounce transition and emits no b_* pulse.
- Collisions:
  - Digit accept in the same cycle a consume or clear takes effect: the new digit survives, giving userInput=code and digit_count=1.
  - A consume or clear always erases digits accepted earlier.
- A button held through reset is seen as pressed and gives one pulse 3 ticks after reset release.
- Reset asserted mid-scan or mid-debounce aborts all activity immediately (asynchronous); no pulse is emitted.

Test Plan:
Bench parameters for all scenarios: SCAN_CYCLES=4, KEY_STABLE=2, DEB_CYCLES=8.
1. Hold row 1/col 2, then release → exactly one key_strobe; userInput=16'h0006, digit_count=1, inputValid=1; no second strobe while the key stays held.
2. Enter keys 1,2,3,4,5 with releases between → userInput=16'h2345, digit_count=4.
3. With userInput=16'h00AB, press load for 3 ticks → b_load high one clock with userInput=16'h00AB and inputValid=1; next clock userInput=0, inputValid=0.
4. Press keys row0/col0 and row2/col3 together → no key_strobe; release both, then press row0/col0 alone → strobe, code 0.
5. Bounce storeinc (toggle every 3 clocks for 40 clocks), then hold steady → exactly one b_storeinc pulse; press clear → userInput=0 with no b_* pulse.
6. Assert rst_n low during a column-2 dwell with a key pressed → col_n=4'b1110, all outputs 0; after release, the key is re-accepted after KEY_STABLE scans.

Source files
------------

// File: rtl/front_panel_input.sv
// Front-panel input front end: 4x4 hex keypad scan/debounce into a 16-bit entry
// value, plus debounced command buttons that emit one-clock pulses and consume the entry.
module front_panel_input #(
  parameter int SCAN_CYCLES = 1000,
  parameter int KEY_STABLE  = 3,
  parameter int DEB_CYCLES  = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  col_n,
  input  logic [3:0]  row_n,
  input  logic [12:0] btn_n,
  output logic        b_step,
  output logic        b_reset,
  output logic        b_runhalt,
  output logic        b_storeinc,
  output logic        b_irq,
  output logic        b_dec,
  output logic        b_load,
  output logic        b_toA,
  output logic        b_toSP,
  output logic        b_toX,
  output logic        b_toY,
  output logic        b_toPC,
  output logic [15:0] userInput,
  output logic        inputValid,
  output logic [2:0]  digit_count,
  output logic        key_strobe
);
  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int KW = $clog2(KEY_STABLE + 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  logic [3:0]       row_s1_q, row_s2_q;
  logic [12:0]      btn_s1_q, btn_s2_q;
  logic [SW-1:0]    scan_cnt_q, scan_cnt_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       nkeys_q, nkeys_d;
  logic [3:0]       code_q, code_d;
  logic [0:0]       state_q, state_d;
  logic [KW-1:0]    stab_q, stab_d, stab_nx;
  logic [3:0]       last_q, last_d;
  logic [15:0]      entry_q, entry_d;
  logic [2:0]       dcnt_q, dcnt_d;
  logic             strobe_q, strobe_d;
  logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
  logic [12:0][1:0] hist_q, hist_d;
  logic [12:0]      deb_q, deb_d;
  logic [11:0]      pulse_q, pulse_d;

  logic        dwell_end, scan_end, tick, accept, clr, consume;
  logic [2:0]  n_col, tot;
  logic [1:0]  r_col;
  logic [3:0]  mcode;
  logic [12:0] btn_p, rise;

  always_comb begin
    dwell_end = scan_cnt_q == SW'(SCAN_CYCLES - 1);
    scan_end  = dwell_end && (col_q == 2'd3);
    n_col = 3'd0;
    r_col = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2_q[r]) begin
        n_col = n_col + 3'd1;
        r_col = 2'(r);
      end
    end
    // Running key count saturates at 2 (multi); the code only matters when exactly one key is seen.
    tot   = {1'b0, nkeys_q} + n_col;
    mcode = (nkeys_q == 2'd0 && n_col == 3'd1) ? {r_col, col_q} : code_q;

    scan_cnt_d = dwell_end ? '0 : scan_cnt_q + SW'(1);
    col_d      = dwell_end ? col_q + 2'd1 : col_q;
    nkeys_d    = nkeys_q;
    code_d     = code_q;
    if (dwell_end) begin
      nkeys_d = scan_end ? 2'd0 : ((tot >= 3'd2) ? 2'd2 : tot[1:0]);
      code_d  = scan_end ? 4'd0 : mcode;
    end

    accept  = 1'b0;
    state_d = state_q;
    stab_d  = stab_q;
    last_d  = last_q;
    stab_nx = stab_q + KW'(1);
    if (scan_end) begin
      if (state_q == ST_IDLE) begin
        if (tot == 3'd1) begin
          if (stab_q == '0 || mcode != last_q) stab_nx = KW'(1);
          last_d = mcode;
          if (stab_nx == KW'(KEY_STABLE)) begin
            accept  = 1'b1;
            state_d = ST_HELD;
            stab_d  = '0;
          end else begin
            stab_d = stab_nx;
          end
        end else begin
          stab_d = '0;
        end
      end else begin
        if (tot == 3'd0) begin
          if (stab_nx == KW'(KEY_STABLE)) begin
            state_d = ST_IDLE;
            stab_d  = '0;
          end else begin
            stab_d = stab_nx;
          end
        end else begin
          stab_d = '0;
        end
      end
    end

    tick      = deb_cnt_q == DW'(DEB_CYCLES - 1);
    deb_cnt_d = tick ? '0 : deb_cnt_q + DW'(1);
    btn_p     = ~btn_s2_q;
    hist_d    = hist_q;
    deb_d     = deb_q;
    if (tick) begin
      for (int i = 0; i < 13; i++) begin
        hist_d[i] = {hist_q[i][0], btn_p[i]};
        if (btn_p[i] && (&hist_q[i]))        deb_d[i] = 1'b1;
        else if (!btn_p[i] && !(|hist_q[i])) deb_d[i] = 1'b0;
      end
    end
    rise    = deb_d & ~deb_q;
    pulse_d = rise[11:0];
    clr     = rise[12];
    consume = |pulse_q;

    // A digit accepted in the same cycle as a clear/consume survives as the sole digit.
    strobe_d = accept;
    entry_d  = entry_q;
    dcnt_d   = dcnt_q;
    if (accept) begin
      if (consume || clr) begin
        entry_d = {12'h000, mcode};
        dcnt_d  = 3'd1;
      end else begin
        entry_d = {entry_q[11:0], mcode};
        dcnt_d  = (dcnt_q == 3'd4) ? 3'd4 : dcnt_q + 3'd1;
      end
    end else if (consume || clr) begin
      entry_d = '0;
      dcnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q   <= '1;
      row_s2_q   <= '1;
      btn_s1_q   <= '1;
      btn_s2_q   <= '1;
      scan_cnt_q <= '0;
      col_q      <= '0;
      nkeys_q    <= '0;
      code_q     <= '0;
      state_q    <= ST_IDLE;
      stab_q     <= '0;
      last_q     <= '0;
      entry_q    <= '0;
      dcnt_q     <= '0;
      strobe_q   <= 1'b0;
      deb_cnt_q  <= '0;
      hist_q     <= '0;
      deb_q      <= '0;
      pulse_q    <= '0;
    end else begin
      row_s1_q   <= row_n;
      row_s2_q   <= row_s1_q;
      btn_s1_q   <= btn_n;
      btn_s2_q   <= btn_s1_q;
      scan_cnt_q <= scan_cnt_d;
      col_q      <= col_d;
      nkeys_q    <= nkeys_d;
      code_q     <= code_d;
      state_q    <= state_d;
      stab_q     <= stab_d;
      last_q     <= last_d;
      entry_q    <= entry_d;
      dcnt_q     <= dcnt_d;
      strobe_q   <= strobe_d;
      deb_cnt_q  <= deb_cnt_d;
      hist_q     <= hist_d;
      deb_q      <= deb_d;
      pulse_q    <= pulse_d;
    end
  end

  assign col_n       = ~(4'b0001 << col_q);
  assign userInput   = entry_q;
  assign digit_count = dcnt_q;
  assign inputValid  = dcnt_q != 3'd0;
  assign key_strobe  = strobe_q;
  assign b_step      = pulse_q[0];
  assign b_reset     = pulse_q[1];
  assign b_runhalt   = pulse_q[2];
  assign b_storeinc  = pulse_q[3];
  assign b_irq       = pulse_q[4];
  assign b_dec       = pulse_q[5];
  assign b_load      = pulse_q[6];
  assign b_toA       = pulse_q[7];
  assign b_toSP      = pulse_q[8];
  assign b_toX       = pulse_q[9];
  assign b_toY       = pulse_q[10];
  assign b_toPC      = pulse_q[11];
endmodule

// File: tb/tb_front_panel_input.sv
// Bench for front_panel_input: keypad matrix model, button stimulus, and a digit-queue
// reference model of the entry value.
module tb_front_panel_input;
  localparam int SC   = 4;
  localparam int KS   = 2;
  localparam int DC   = 8;
  localparam int SCAN = 4 * SC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col_n, row_n;
  logic [12:0] btn_n = '1;
  logic [3:0][3:0] keymat = '0;  // keymat[row][col], 1 = pressed
  logic b_step, b_reset, b_runhalt, b_storeinc, b_irq, b_dec, b_load;
  logic b_toA, b_toSP, b_toX, b_toY, b_toPC;
  logic [15:0] userInput;
  logic        inputValid, key_strobe;
  logic [2:0]  digit_count;
  logic [11:0] bv;

  int total = 0, passed = 0;
  int strobe_cnt = 0;
  logic [3:0] last_code = '0;
  int pulse_cnt [12];
  logic [3:0] q [$];

  front_panel_input #(.SCAN_CYCLES(SC), .KEY_STABLE(KS), .DEB_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .col_n(col_n), .row_n(row_n), .btn_n(btn_n),
    .b_step(b_step), .b_reset(b_reset), .b_runhalt(b_runhalt), .b_storeinc(b_storeinc),
    .b_irq(b_irq), .b_dec(b_dec), .b_load(b_load), .b_toA(b_toA), .b_toSP(b_toSP),
    .b_toX(b_toX), .b_toY(b_toY), .b_toPC(b_toPC), .userInput(userInput),
    .inputValid(inputValid), .digit_count(digit_count), .key_strobe(key_strobe)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < 4; r++) row_n[r] = ~(|(keymat[r] & ~col_n));
  end

  assign bv = {b_toPC, b_toY, b_toX, b_toSP, b_toA, b_load, b_dec, b_irq,
               b_storeinc, b_runhalt, b_reset, b_step};

  initial for (int i = 0; i < 12; i++) pulse_cnt[i] = 0;

  always @(negedge clk) begin
    if (key_strobe === 1'b1) begin
      strobe_cnt++;
      last_code = userInput[3:0];
    end
    for (int j = 0; j < 12; j++) if (bv[j] === 1'b1) pulse_cnt[j]++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] mval();
    logic [15:0] v = '0;
    foreach (q[i]) v = {v[11:0], q[i]};
    return v;
  endfunction

  function automatic int mcnt();
    return (q.size() > 4) ? 4 : q.size();
  endfunction

  function automatic int psum();
    int s = 0;
    for (int i = 0; i < 12; i++) s += pulse_cnt[i];
    return s;
  endfunction

  task automatic check_entry(input string tag);
    chk({tag, "_val"}, userInput, mval());
    chk({tag, "_cnt"}, digit_count, mcnt());
    chk({tag, "_valid"}, inputValid, q.size() != 0);
  endtask

  task automatic enter_key(input int code);
    int s0 = strobe_cnt;
    keymat[code / 4][code % 4] = 1'b1;
    repeat (6 * SCAN) @(negedge clk);
    chk("key_one_strobe", strobe_cnt - s0, 1);
    chk("key_code", last_code, code);
    keymat = '0;
    repeat (5 * SCAN) @(negedge clk);
    q.push_back(code[3:0]);
    check_entry("key");
  endtask

  task automatic press_cmd(input int i, input logic [15:0] pre, input logic pre_valid);
    logic found = 1'b0;
    logic [11:0] e = '0;
    e[i] = 1'b1;
    btn_n[i] = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      @(negedge clk);
      if (bv[i] === 1'b1) found = 1'b1;
    end
    chk("cmd_pulse_seen", found, 1'b1);
    if (found) begin
      chk("cmd_pre_val", userInput, pre);
      chk("cmd_pre_valid", inputValid, pre_valid);
      chk("cmd_solo", bv, e);
      @(negedge clk);
      chk("cmd_post_val", userInput, 16'h0);
      chk("cmd_post_valid", inputValid, 1'b0);
      chk("cmd_pulse_len", bv, 12'h0);
    end
    q.delete();
    repeat (48) @(negedge clk);
    btn_n[i] = 1'b1;
    repeat (48) @(negedge clk);
  endtask

  task automatic press_clear();
    int p0 = psum();
    btn_n[12] = 1'b0;
    repeat (48) @(negedge clk);
    chk("clr_val", userInput, 16'h0);
    chk("clr_cnt", digit_count, 3'd0);
    chk("clr_no_pulse", psum() - p0, 0);
    btn_n[12] = 1'b1;
    repeat (48) @(negedge clk);
    q.delete();
  endtask

  initial begin
    int s0, p0, code;
    logic found;
    repeat (3) @(negedge clk);
    chk("rst_col", col_n, 4'b1110);
    chk("rst_val", userInput, 16'h0);
    chk("rst_cnt", digit_count, 3'd0);
    chk("rst_valid", inputValid, 1'b0);
    chk("rst_strobe", key_strobe, 1'b0);
    chk("rst_b", bv, 12'h0);
    rst_n = 1'b1;
    repeat (2 * SCAN) @(negedge clk);

    // single key, no auto-repeat
    enter_key(6);
    chk("s1_val", userInput, 16'h0006);
    chk("s1_cnt", digit_count, 3'd1);

    // five digits: oldest falls off
    for (int d = 1; d <= 5; d++) enter_key(d);
    chk("s2_val", userInput, 16'h2345);
    chk("s2_cnt", digit_count, 3'd4);
    press_clear();

    // consume via load
    enter_key(10);
    enter_key(11);
    chk("s3_val", userInput, 16'h00AB);
    press_cmd(6, 16'h00AB, 1'b1);

    // two keys together are rejected
    s0 = strobe_cnt;
    keymat[0][0] = 1'b1;
    keymat[2][3] = 1'b1;
    repeat (6 * SCAN) @(negedge clk);
    chk("s4_multi_none", strobe_cnt - s0, 0);
    keymat = '0;
    repeat (5 * SCAN) @(negedge clk);
    chk("s4_release_none", strobe_cnt - s0, 0);
    enter_key(0);

    // bouncing storeinc gives one pulse
    p0 = pulse_cnt[3];
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) btn_n[3] = ~btn_n[3];
      @(negedge clk);
    end
    btn_n[3] = 1'b0;
    repeat (48) @(negedge clk);
    chk("s5_one_pulse", pulse_cnt[3] - p0, 1);
    q.delete();
    chk("s5_consumed", digit_count, 3'd0);
    btn_n[3] = 1'b1;
    repeat (48) @(negedge clk);
    chk("s5_no_extra", pulse_cnt[3] - p0, 1);
    enter_key(7);
    press_clear();

    // randomized digits with occasional consumes
    for (int n = 0; n < 8; n++) begin
      code = int'($urandom_range(15));
      enter_key(code);
      if ($urandom_range(2) == 0) press_cmd(int'($urandom_range(11)), mval(), q.size() != 0);
    end

    // reset mid-scan during column 2 with a key held
    keymat[2][1] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (col_n === 4'b1011) found = 1'b1;
    end
    chk("s6_col2_seen", found, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("s6_col", col_n, 4'b1110);
    chk("s6_val", userInput, 16'h0);
    chk("s6_cnt", digit_count, 3'd0);
    chk("s6_valid", inputValid, 1'b0);
    chk("s6_strobe", key_strobe, 1'b0);
    chk("s6_b", bv, 12'h0);
    q.delete();
    repeat (3) @(negedge clk);
    s0 = strobe_cnt;
    rst_n = 1'b1;
    repeat (6 * SCAN) @(negedge clk);
    chk("s6_reaccept", strobe_cnt - s0, 1);
    chk("s6_code", last_code, 4'd9);
    q.push_back(4'd9);
    check_entry("s6");
    keymat = '0;
    repeat (5 * SCAN) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
